// File: rtl/iq_parallel_to_serial_fifo_if.sv
// Handshake bundle for iq_parallel_to_serial_fifo: parallel words in, serial lane beats out, status.
// The DUT connects through the slave modport; the word source / beat sink side uses master.
interface iq_parallel_to_serial_fifo_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 1,
  parameter int DEPTH  = 4
);
  logic [LANES*DATA_W-1:0]    i_par_data;
  logic                       i_par_valid;
  logic                       o_par_ready;
  logic                       i_q_first;
  logic [DATA_W-1:0]          o_ser_data;
  logic                       o_ser_valid;
  logic                       i_ser_ready;
  logic                       o_ser_last;
  logic [$clog2(DEPTH+1)-1:0] o_fifo_level;
  logic                       o_busy;

  modport slave (
    input  i_par_data, i_par_valid, i_q_first, i_ser_ready,
    output o_par_ready, o_ser_data, o_ser_valid, o_ser_last, o_fifo_level, o_busy
  );

  modport master (
    output i_par_data, i_par_valid, i_q_first, i_ser_ready,
    input  o_par_ready, o_ser_data, o_ser_valid, o_ser_last, o_fifo_level, o_busy
  );
endinterface

// File: rtl/iq_parallel_to_serial_fifo.sv
// Buffers LANES-wide I/Q words in a DEPTH-word FIFO and serialises them one lane per beat.
// Optional macro PTS_PARITY_BEAT_EN appends an XOR-of-all-lanes beat to every word.
module iq_parallel_to_serial_fifo #(
  parameter int LANES  = 2,
  parameter int DATA_W = 1,
  parameter int DEPTH  = 4
) (
  input logic                        i_clk,
  input logic                        i_rst,
  iq_parallel_to_serial_fifo_if.slave bus
);
  localparam int WORD_W = LANES * DATA_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH + 1);
`ifdef PTS_PARITY_BEAT_EN
  localparam int BEATS  = LANES + 1;
`else
  localparam int BEATS  = LANES;
`endif
  localparam int BEAT_W = $clog2(BEATS);
  localparam int PAIRED = LANES - (LANES % 2);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              parReady_q;

  state_t            state_q;
  logic [WORD_W-1:0] shift_q;
  logic              qFirst_q;
  logic [BEAT_W-1:0] beat_q, beatNext;
  logic [DATA_W-1:0] serData_q;
  logic              serValid_q, serLast_q, busy_q;

  logic              push, pop, fifoEmpty, beatTaken;
  logic [WORD_W-1:0] headWord;

  // Beats past the last lane carry the parity; otherwise pick the lane, swapping I/Q pairs in Q-first mode.
  function automatic logic [DATA_W-1:0] beatData(input logic [WORD_W-1:0] word,
                                                 input logic qf, input int idx);
    logic [DATA_W-1:0] acc;
    int lane;
    acc = '0;
    if (idx >= LANES) begin
      for (int k = 0; k < LANES; k++) acc ^= word[k*DATA_W +: DATA_W];
    end else begin
      lane = (qf && idx < PAIRED) ? (idx ^ 1) : idx;
      acc  = word[lane*DATA_W +: DATA_W];
    end
    return acc;
  endfunction

  assign fifoEmpty = (level_q == '0);
  assign headWord  = mem_q[rdPtr_q];
  assign beatTaken = (state_q == SHIFT) && bus.i_ser_ready;
  assign push      = bus.i_par_valid && parReady_q;
  assign pop       = !fifoEmpty && ((state_q == IDLE) || (beatTaken && serLast_q));
  assign beatNext  = beat_q + 1'b1;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Ready is registered from the next level, so a full FIFO refuses a push even while popping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      parReady_q <= 1'b1;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      level_q    <= level_d;
      parReady_q <= (level_d != FULL_LVL);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wrPtr_q] <= bus.i_par_data;
  end

  // A pop always means a load, whether from IDLE or back-to-back after the last beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      qFirst_q   <= 1'b0;
      beat_q     <= '0;
      serData_q  <= '0;
      serValid_q <= 1'b0;
      serLast_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else if (pop) begin
      state_q    <= SHIFT;
      shift_q    <= headWord;
      qFirst_q   <= bus.i_q_first;
      beat_q     <= '0;
      serData_q  <= beatData(headWord, bus.i_q_first, 0);
      serValid_q <= 1'b1;
      serLast_q  <= 1'b0;
      busy_q     <= 1'b1;
    end else if (beatTaken) begin
      if (serLast_q) begin
        state_q    <= IDLE;
        beat_q     <= '0;
        serData_q  <= '0;
        serValid_q <= 1'b0;
        serLast_q  <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        beat_q    <= beatNext;
        serData_q <= beatData(shift_q, qFirst_q, int'(beatNext));
        serLast_q <= (beatNext == LAST_BEAT);
      end
    end
  end

  assign bus.o_par_ready  = parReady_q;
  assign bus.o_ser_data   = serData_q;
  assign bus.o_ser_valid  = serValid_q;
  assign bus.o_ser_last   = serLast_q;
  assign bus.o_fifo_level = level_q;
  assign bus.o_busy       = busy_q;
endmodule

// File: tb/tb_iq_parallel_to_serial_fifo.sv
// Self-checking bench for iq_parallel_to_serial_fifo; a queue of expected beats is built from each accepted word.
// Parity-beat expectations follow PTS_PARITY_BEAT_EN when it is defined for the build.
module tb_iq_parallel_to_serial_fifo;
  localparam int L  = 2;
  localparam int DW = 1;
  localparam int D  = 4;
  localparam int W  = L * DW;
`ifdef PTS_PARITY_BEAT_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif
  localparam int BEATS = PARITY ? L + 1 : L;

  logic clk = 1'b0;
  logic rst = 1'b1;

  iq_parallel_to_serial_fifo_if #(.LANES(L), .DATA_W(DW), .DEPTH(D)) bus();

  iq_parallel_to_serial_fifo #(.LANES(L), .DATA_W(DW), .DEPTH(D)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [DW:0] expQ[$];

  // Expected beats of one word as {last, data}, straight from the lane-order and parity rules.
  function automatic void modelPush(input logic [W-1:0] word, input logic qf);
    logic [DW-1:0] par;
    logic [DW-1:0] s;
    int src;
    par = '0;
    for (int k = 0; k < L; k++) begin
      src = k;
      if (qf) begin
        if (k % 2 == 0) src = (k + 1 < L) ? k + 1 : k;
        else            src = k - 1;
      end
      s = word[src*DW +: DW];
      par ^= s;
      expQ.push_back({(k == L - 1) && !PARITY, s});
    end
    if (PARITY) expQ.push_back({1'b1, par});
  endfunction

  // One clock: drive inputs at the falling edge, note what the next rising edge will accept, advance.
  task automatic cycle(input logic pv, input logic [W-1:0] pd, input logic qf, input logic sr,
                       output logic pushed, output logic beat,
                       output logic [DW-1:0] bd, output logic bl);
    bus.i_par_valid = pv;
    bus.i_par_data  = pd;
    bus.i_q_first   = qf;
    bus.i_ser_ready = sr;
    pushed = pv && bus.o_par_ready;
    beat   = bus.o_ser_valid && sr;
    bd     = bus.o_ser_data;
    bl     = bus.o_ser_last;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vecs++; if (bus.o_ser_valid !== 1'b0) begin errs++; $display("[TB] FAIL reset_ser_valid: got %b want 0", bus.o_ser_valid); end
    vecs++; if (bus.o_ser_data !== '0) begin errs++; $display("[TB] FAIL reset_ser_data: got %b want 0", bus.o_ser_data); end
    vecs++; if (bus.o_ser_last !== 1'b0) begin errs++; $display("[TB] FAIL reset_ser_last: got %b want 0", bus.o_ser_last); end
    vecs++; if (bus.o_busy !== 1'b0) begin errs++; $display("[TB] FAIL reset_busy: got %b want 0", bus.o_busy); end
    vecs++; if (bus.o_fifo_level !== '0) begin errs++; $display("[TB] FAIL reset_level: got %0d want 0", bus.o_fifo_level); end
    rst = 1'b0;
    @(negedge clk);
    vecs++; if (bus.o_par_ready !== 1'b1) begin errs++; $display("[TB] FAIL reset_par_ready: got %b want 1", bus.o_par_ready); end
  endtask

  task automatic test_single_word();
    logic p, b, bl;
    logic [DW-1:0] bd;
    logic [DW-1:0] expD[3];
    logic expL[3];
    int nB, firstIdx;
    expD[0] = 1'b0; expD[1] = 1'b1; expD[2] = 1'b1;
    expL[0] = 1'b0; expL[1] = !PARITY; expL[2] = PARITY;
    nB = 0; firstIdx = -1;
    cycle(1'b1, 2'b10, 1'b0, 1'b1, p, b, bd, bl);
    vecs++; if (p !== 1'b1) begin errs++; $display("[TB] FAIL single_push: got %b want 1", p); end
    for (int c = 1; c <= 12 && nB < BEATS; c++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, p, b, bd, bl);
      if (b) begin
        if (firstIdx < 0) firstIdx = c;
        vecs++;
        if (bd !== expD[nB] || bl !== expL[nB]) begin
          errs++; $display("[TB] FAIL single_beat%0d: got data=%b last=%b want data=%b last=%b", nB, bd, bl, expD[nB], expL[nB]);
        end
        nB++;
      end
    end
    vecs++; if (firstIdx != 2) begin errs++; $display("[TB] FAIL single_latency: got %0d edges want 2", firstIdx); end
    vecs++; if (nB != BEATS) begin errs++; $display("[TB] FAIL single_count: got %0d beats want %0d", nB, BEATS); end
    vecs++; if (bus.o_busy !== 1'b0) begin errs++; $display("[TB] FAIL single_busy_after: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_back_to_back();
    logic p, b, bl;
    logic [DW-1:0] bd;
    logic [DW:0] e;
    logic [W-1:0] w;
    int firstIdx, lastIdx, maxLvl, nB, nPush;
    firstIdx = -1; lastIdx = -1; maxLvl = 0; nB = 0; nPush = 0;
    expQ.delete();
    for (int c = 0; c < 40 && (c < 3 || expQ.size() > 0); c++) begin
      w = W'($urandom);
      cycle(c < 3, w, 1'b0, 1'b1, p, b, bd, bl);
      if (b) begin
        if (firstIdx < 0) firstIdx = c;
        lastIdx = c; nB++;
        vecs++;
        if (expQ.size() == 0) begin errs++; $display("[TB] FAIL b2b_extra_beat: got data=%b want no beat", bd); end
        else begin
          e = expQ.pop_front();
          if ({bl, bd} !== e) begin errs++; $display("[TB] FAIL b2b_beat: got last/data=%b want %b", {bl, bd}, e); end
        end
      end
      if (p) begin modelPush(w, 1'b0); nPush++; end
      if (int'(bus.o_fifo_level) > maxLvl) maxLvl = int'(bus.o_fifo_level);
    end
    vecs++; if (nPush != 3) begin errs++; $display("[TB] FAIL b2b_pushes: got %0d want 3", nPush); end
    vecs++; if (nB != 3 * BEATS) begin errs++; $display("[TB] FAIL b2b_count: got %0d want %0d", nB, 3 * BEATS); end
    vecs++; if (lastIdx - firstIdx + 1 != 3 * BEATS) begin errs++; $display("[TB] FAIL b2b_bubble: got span %0d want %0d", lastIdx - firstIdx + 1, 3 * BEATS); end
    vecs++; if (maxLvl != 2) begin errs++; $display("[TB] FAIL b2b_peak_level: got %0d want 2", maxLvl); end
    vecs++; if (bus.o_fifo_level !== '0) begin errs++; $display("[TB] FAIL b2b_end_level: got %0d want 0", bus.o_fifo_level); end
  endtask

  task automatic test_backpressure();
    logic p, b, bl;
    logic [DW-1:0] bd;
    logic [DW:0] e;
    logic [W-1:0] words[6];
    int idx, nB, stalled;
    idx = 0; nB = 0; stalled = 0;
    for (int i = 0; i < 6; i++) words[i] = W'($urandom);
    expQ.delete();
    for (int c = 0; c < 20 && idx < 5; c++) begin
      cycle(1'b1, words[idx], 1'b0, 1'b0, p, b, bd, bl);
      if (p) begin modelPush(words[idx], 1'b0); idx++; end
    end
    vecs++; if (idx != 5) begin errs++; $display("[TB] FAIL bp_fill: got %0d pushes want 5", idx); end
    vecs++; if (bus.o_fifo_level !== 3'd4) begin errs++; $display("[TB] FAIL bp_level_full: got %0d want 4", bus.o_fifo_level); end
    vecs++; if (bus.o_par_ready !== 1'b0) begin errs++; $display("[TB] FAIL bp_ready_full: got %b want 0", bus.o_par_ready); end
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, words[5], 1'b0, 1'b0, p, b, bd, bl);
      if (p && idx < 6) begin stalled++; modelPush(words[idx], 1'b0); idx++; end
    end
    vecs++; if (stalled != 0) begin errs++; $display("[TB] FAIL bp_stall: got %0d pushes while full want 0", stalled); end
    for (int c = 0; c < 60 && (idx < 6 || expQ.size() > 0); c++) begin
      cycle(idx < 6, words[idx < 6 ? idx : 5], 1'b0, 1'b1, p, b, bd, bl);
      if (b) begin
        nB++; vecs++;
        if (expQ.size() == 0) begin errs++; $display("[TB] FAIL bp_extra_beat: got data=%b want no beat", bd); end
        else begin
          e = expQ.pop_front();
          if ({bl, bd} !== e) begin errs++; $display("[TB] FAIL bp_beat: got last/data=%b want %b", {bl, bd}, e); end
        end
      end
      if (p && idx < 6) begin modelPush(words[idx], 1'b0); idx++; end
    end
    vecs++; if (nB != 6 * BEATS) begin errs++; $display("[TB] FAIL bp_count: got %0d beats want %0d", nB, 6 * BEATS); end
    vecs++; if (expQ.size() != 0) begin errs++; $display("[TB] FAIL bp_drain: got %0d beats missing want 0", expQ.size()); end
  endtask

  task automatic test_q_first();
    logic p, b, bl;
    logic [DW-1:0] bd;
    logic [DW:0] e;
    int nB;
    nB = 0;
    expQ.delete();
    cycle(1'b1, 2'b01, 1'b1, 1'b0, p, b, bd, bl);
    vecs++; if (p !== 1'b1) begin errs++; $display("[TB] FAIL qf_push: got %b want 1", p); end
    if (p) modelPush(2'b01, 1'b1);
    for (int c = 0; c < 6 && bus.o_ser_valid !== 1'b1; c++) cycle(1'b0, '0, 1'b1, 1'b0, p, b, bd, bl);
    vecs++; if (bus.o_ser_valid !== 1'b1) begin errs++; $display("[TB] FAIL qf_valid_timeout: got %b want 1", bus.o_ser_valid); end
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, '0, 1'b0, 1'b0, p, b, bd, bl);
      vecs++;
      if (bus.o_ser_valid !== 1'b1 || expQ.size() == 0 || bus.o_ser_data !== expQ[0][DW-1:0]) begin
        errs++; $display("[TB] FAIL qf_stall_hold: got valid=%b data=%b want valid=1 data=0", bus.o_ser_valid, bus.o_ser_data);
      end
    end
    for (int c = 0; c < 10 && expQ.size() > 0; c++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, p, b, bd, bl);
      if (b) begin
        nB++; vecs++;
        e = expQ.pop_front();
        if ({bl, bd} !== e) begin errs++; $display("[TB] FAIL qf_beat: got last/data=%b want %b", {bl, bd}, e); end
      end
    end
    vecs++; if (nB != BEATS) begin errs++; $display("[TB] FAIL qf_count: got %0d want %0d", nB, BEATS); end
  endtask

  task automatic test_reset_midword();
    logic p, b, bl;
    logic [DW-1:0] bd;
    int nPush, nStale;
    nPush = 0; nStale = 0;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, W'($urandom), 1'b0, 1'b0, p, b, bd, bl);
      if (p) nPush++;
    end
    vecs++; if (nPush != 3) begin errs++; $display("[TB] FAIL rstmid_pushes: got %0d want 3", nPush); end
    vecs++; if (bus.o_fifo_level !== 3'd2) begin errs++; $display("[TB] FAIL rstmid_level_pre: got %0d want 2", bus.o_fifo_level); end
    vecs++; if (bus.o_ser_valid !== 1'b1) begin errs++; $display("[TB] FAIL rstmid_valid_pre: got %b want 1", bus.o_ser_valid); end
    bus.i_par_valid = 1'b0;
    rst = 1'b1;
    #1;
    vecs++; if (bus.o_ser_valid !== 1'b0) begin errs++; $display("[TB] FAIL rstmid_valid: got %b want 0", bus.o_ser_valid); end
    vecs++; if (bus.o_fifo_level !== '0) begin errs++; $display("[TB] FAIL rstmid_level: got %0d want 0", bus.o_fifo_level); end
    vecs++; if (bus.o_busy !== 1'b0) begin errs++; $display("[TB] FAIL rstmid_busy: got %b want 0", bus.o_busy); end
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, p, b, bd, bl);
      if (b) nStale++;
    end
    vecs++; if (nStale != 0) begin errs++; $display("[TB] FAIL rstmid_stale: got %0d beats want 0", nStale); end
    vecs++; if (bus.o_par_ready !== 1'b1) begin errs++; $display("[TB] FAIL rstmid_ready: got %b want 1", bus.o_par_ready); end
  endtask

`ifdef PTS_PARITY_BEAT_EN
  task automatic test_parity();
    logic p, b, bl;
    logic [DW-1:0] bd;
    logic [DW-1:0] expD[3];
    logic expL[3];
    int nB;
    expD[0] = 1'b1; expD[1] = 1'b1; expD[2] = 1'b0;
    expL[0] = 1'b0; expL[1] = 1'b0; expL[2] = 1'b1;
    nB = 0;
    cycle(1'b1, 2'b11, 1'b0, 1'b1, p, b, bd, bl);
    for (int c = 0; c < 12 && nB < 3; c++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, p, b, bd, bl);
      if (b) begin
        vecs++;
        if (bd !== expD[nB] || bl !== expL[nB]) begin
          errs++; $display("[TB] FAIL parity_beat%0d: got data=%b last=%b want data=%b last=%b", nB, bd, bl, expD[nB], expL[nB]);
        end
        nB++;
      end
    end
    vecs++; if (nB != 3) begin errs++; $display("[TB] FAIL parity_count: got %0d want 3", nB); end
  endtask
`endif

  task automatic test_random();
    logic p, b, bl, pv, sr, qf;
    logic [DW-1:0] bd;
    logic [DW:0] e;
    logic [W-1:0] w;
    for (int seg = 0; seg < 2; seg++) begin
      qf = (seg == 1);
      expQ.delete();
      w = W'($urandom);
      for (int c = 0; c < 150; c++) begin
        pv = ($urandom_range(0, 3) != 0);
        sr = ($urandom_range(0, 2) != 0);
        cycle(pv, w, qf, sr, p, b, bd, bl);
        if (b) begin
          vecs++;
          if (expQ.size() == 0) begin errs++; $display("[TB] FAIL rand_extra_beat: got data=%b want no beat", bd); end
          else begin
            e = expQ.pop_front();
            if ({bl, bd} !== e) begin errs++; $display("[TB] FAIL rand_beat: got last/data=%b want %b", {bl, bd}, e); end
          end
        end
        if (p) begin modelPush(w, qf); w = W'($urandom); end
        vecs++; if (int'(bus.o_fifo_level) > D) begin errs++; $display("[TB] FAIL rand_level_bound: got %0d want <= %0d", bus.o_fifo_level, D); end
      end
      for (int c = 0; c < 60 && expQ.size() > 0; c++) begin
        cycle(1'b0, w, qf, 1'b1, p, b, bd, bl);
        if (b) begin
          vecs++;
          e = expQ.pop_front();
          if ({bl, bd} !== e) begin errs++; $display("[TB] FAIL rand_drain_beat: got last/data=%b want %b", {bl, bd}, e); end
        end
      end
      vecs++; if (expQ.size() != 0) begin errs++; $display("[TB] FAIL rand_drain: got %0d beats missing want 0", expQ.size()); end
      vecs++; if (bus.o_busy !== 1'b0 || bus.o_fifo_level !== '0) begin
        errs++; $display("[TB] FAIL rand_idle: got busy=%b level=%0d want busy=0 level=0", bus.o_busy, bus.o_fifo_level);
      end
    end
  endtask

  initial begin
    bus.i_par_valid = 1'b0;
    bus.i_par_data  = '0;
    bus.i_q_first   = 1'b0;
    bus.i_ser_ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_q_first();
    test_reset_midword();
`ifdef PTS_PARITY_BEAT_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
